// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_pkg
//  Brief    : Shared defaults and selector-width helper for the N-way demux.
//  Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int DEMUX_WIDTH_DEF    = 16;
    localparam int DEMUX_CHANNELS_DEF = 8;

    // Never below one bit, so a selector port always exists.
    function automatic int demux_sel_w(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module   : demux_slot
//  Brief    : One-entry output register (data + valid) for a single channel.
//  Revision : 1.0
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             free,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A full slot counts as free when it drains this cycle.
    assign free      = ~r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Data only moves on a load, so it holds under backpressure and when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (load) begin
                r_valid <= 1'b1;
                r_data  <= load_data;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_nway_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_nway_reg
//  Brief    : Registered 1-to-N demultiplexer with broadcast and sticky
//             out-of-range selector flag.
//  Revision : 1.0
// ============================================================================
module demux_nway_reg
    import demux_pkg::*;
#(
    parameter int WIDTH    = DEMUX_WIDTH_DEF,
    parameter int CHANNELS = DEMUX_CHANNELS_DEF,
    parameter int SEL_W    = demux_sel_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic                      err_oor
);

    localparam logic [31:0] C_CHANNELS = 32'(CHANNELS);

    logic [31:0]         w_sel_ext;
    logic                w_in_range;
    logic                w_sel_free;
    logic                w_accept;
    logic                w_oor_accept;
    logic [CHANNELS-1:0] w_free;
    logic [CHANNELS-1:0] w_load;
    logic                r_err_oor;

    assign w_sel_ext  = 32'(in_sel);
    assign w_in_range = (w_sel_ext < C_CHANNELS);

    // Loop compare avoids indexing past CHANNELS for non-power-of-two counts.
    always_comb begin
        w_sel_free = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_sel_ext == 32'(i)) begin
                w_sel_free = w_free[i];
            end
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &w_free;
        end else if (w_in_range) begin
            in_ready = w_sel_free;
        end
    end

    assign w_accept     = in_valid & in_ready;
    assign w_oor_accept = w_accept & ~in_bcast & ~w_in_range;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
        assign w_load[i] = w_accept & (in_bcast | (w_sel_ext == 32'(i)));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (w_load[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .free      (w_free[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_oor <= 1'b0;
        end else if (w_oor_accept) begin
            r_err_oor <= 1'b1;
        end
    end

    assign err_oor = r_err_oor;

endmodule : demux_nway_reg
`default_nettype wire

// File: doc/demux_nway_reg.md
DEMUX_NWAY_REG -- requirements
Module: demux_nway_reg

Interface
REQ-001 Parameter WIDTH, default 16, sets the data bits per transfer.
REQ-002 Parameter CHANNELS, default 8, sets the number of output channels; the legal range is 2..64, and the value need not be a power of two.
REQ-003 Parameter SEL_W, default $clog2(CHANNELS), sets the selector width; it is derived and SHALL NOT be overridden.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  is the asynchronous, active-high reset.
REQ-006 in_data  input  WIDTH  is the payload to route.
REQ-007 in_sel  input  SEL_W  is the destination channel index.
REQ-008 in_bcast  input  1  requests delivery to every channel; when it is 1, in_sel is ignored.
REQ-009 in_valid  input  1  indicates the upstream transfer request.
REQ-010 in_ready  output  1  indicates the block accepts the transfer this cycle.
REQ-011 out_data  output  CHANNELS*WIDTH  carries the per-channel payloads; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 out_valid  output  CHANNELS  is the per-channel valid.
REQ-013 out_ready  input  CHANNELS  is the per-channel downstream ready.
REQ-014 err_oor  output  1  is a sticky flag meaning an out-of-range selector was accepted.

Function
REQ-015 Each channel SHALL hold a one-entry output slot made of a data register and a valid bit.
REQ-016 A slot is "free" in a cycle when its valid bit is 0, or when its valid bit is 1 and its out_ready is 1 in the same cycle.
REQ-017 Unicast with in_sel < CHANNELS: in_ready = free[in_sel].
REQ-018 Broadcast: in_ready = AND of free[i] over all channels.
REQ-019 Unicast with in_sel >= CHANNELS: in_ready = 1; the transfer is accepted, no slot is written, and err_oor is set to 1 on the next edge.
REQ-020 An accept is defined as in_valid && in_ready at a rising edge.
REQ-021 An accept loads in_data into the target slot(s) and sets their valid bit(s); latency from accept to out_valid is exactly 1 cycle.
REQ-022 A drain is out_valid[i] && out_ready[i] at an edge; a drain without a simultaneous load clears out_valid[i].
REQ-023 A drain and a load on the same slot at the same edge: the load wins, out_valid[i] stays 1, and out_data takes the new value, giving full throughput of one transfer per cycle per channel.
REQ-024 While out_valid[i] = 1 and out_ready[i] = 0, out_data for channel i SHALL stay stable.
REQ-025 A channel that is not written SHALL hold its last out_data value; it is not forced to zero.
REQ-026 in_ready SHALL be combinational from in_sel, in_bcast, out_valid and out_ready, and SHALL NOT depend on in_valid.
REQ-027 A broadcast SHALL never partially load: either all slots are written at the same edge, or none are.
REQ-028 err_oor, once set, remains 1 until reset.

Reset
REQ-029 When reset is asserted, without waiting for a clock edge: out_valid = 0 on all channels, out_data = 0 on all channels, err_oor = 0.
REQ-030 A transfer that is mid-handshake when reset asserts is lost.
REQ-031 in_ready SHALL evaluate per REQ-017 to REQ-019 with every slot empty, so it may read 1 during reset.
REQ-032 No accept SHALL be recorded at any edge while reset is high.
REQ-033 Normal operation resumes at the first rising edge after reset deasserts.

Structure
REQ-034 A shared package demux_pkg SHALL hold the default constants DEMUX_WIDTH_DEF = 16 and DEMUX_CHANNELS_DEF = 8, plus a function returning the selector width for a given channel count.
REQ-035 One sub-module, demux_slot (a single-channel one-entry register with valid, ready, load and data), SHALL be instantiated CHANNELS times through a generate loop.
REQ-036 The top level SHALL contain only the selector decode, the in_ready reduction and err_oor.

Verification
REQ-037 Unicast, CHANNELS=8: send sel=3, data=16'hA5A5, out_ready=all 1 -> out_valid=8'b0000_1000 for exactly one cycle, with channel 3 data = A5A5, one cycle after the accept.
REQ-038 Backpressure: out_ready[5]=0, two back-to-back sends to sel=5 (data 1, then 2) -> first accepted, in_ready=0 on the second; raising out_ready[5] delivers 1, then 2, with no loss or duplication.
REQ-039 Broadcast: out_ready[2]=0 with slot 2 full, bcast data=16'h00FF -> in_ready=0 and no slot changes; after slot 2 drains, all 8 slots load 00FF at the same edge.
REQ-040 Out of range, CHANNELS=6: send sel=7 -> in_ready=1, out_valid remains 0, err_oor=1 and stays 1 through later legal traffic until reset.
REQ-041 Same-edge drain and load on channel 0 with a continuous stream 1..10 -> out_valid[0] stays high for 10 consecutive cycles, data arrives in order, and the output rate is 1 per cycle.
REQ-042 Reset mid-stream: assert reset asynchronously between edges while slots are full -> out_valid=0, out_data=0 and err_oor=0 immediately; the first send after release behaves as in REQ-037.
